// File: rtl/mux_pipe_reg_if.sv
// Handshake and data bundle for one mux_pipe_reg stage: upstream beat,
// select, downstream beat, error flag/counter and counter clear.
interface mux_pipe_reg_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        select;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_err;
  logic [CNT_W-1:0]        err_cnt;
  logic                    clr_err;

  modport master (
    output in_bus, select, in_valid, out_ready, clr_err,
    input  in_ready, out_data, out_valid, out_err, err_cnt
  );

  modport slave (
    input  in_bus, select, in_valid, out_ready, clr_err,
    output in_ready, out_data, out_valid, out_err, err_cnt
  );
endinterface

// File: rtl/mux_pipe_reg.sv
// Registered N:1 datapath mux with valid/ready flow control, a one-entry
// skid buffer, a default word for out-of-range selects and an error counter.
module mux_pipe_reg #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 5,
  parameter int               SEL_W       = 3,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  parameter int               CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_pipe_reg_if.slave   bus
);

  if (NUM_IN < 2 || (2 ** SEL_W) < NUM_IN) begin : g_bad_cfg
    $error("mux_pipe_reg: NUM_IN must be >= 2 and fit in SEL_W select bits");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] sel_data_p0;
  logic             sel_err_p0;
  logic             accept;
  logic             transfer;

  logic [WIDTH-1:0] main_data_p1;
  logic             main_err_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic             skid_err_p1;
  logic             skid_full_p1;
  logic             in_ready_p1;
  logic [CNT_W-1:0] err_cnt_p1;

  logic             vld_nxt;
  logic             skid_full_nxt;
  logic             load_from_skid;
  logic             load_from_in;
  logic             load_skid;

  // Stage p0: select evaluation on the incoming beat
  always_comb begin
    sel_data_p0 = DEFAULT_VAL;
    sel_err_p0  = (int'(bus.select) >= NUM_IN);
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(bus.select) == k) sel_data_p0 = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  assign accept   = bus.in_valid & in_ready_p1;
  assign transfer = vld_p1 & bus.out_ready;

  // The skid entry always drains into main first, which keeps beat order.
  always_comb begin
    vld_nxt        = vld_p1;
    skid_full_nxt  = skid_full_p1;
    load_from_skid = 1'b0;
    load_from_in   = 1'b0;
    load_skid      = 1'b0;
    if (!vld_p1 || transfer) begin
      if (skid_full_p1) begin
        load_from_skid = 1'b1;
        skid_full_nxt  = 1'b0;
        vld_nxt        = 1'b1;
      end else if (accept) begin
        load_from_in = 1'b1;
        vld_nxt      = 1'b1;
      end else begin
        vld_nxt = 1'b0;
      end
    end else if (accept) begin
      load_skid     = 1'b1;
      skid_full_nxt = 1'b1;
    end
  end

  // Stage p1: main output register, skid flag, ready and error counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_p1 <= '0;
      main_err_p1  <= 1'b0;
      vld_p1       <= 1'b0;
      skid_full_p1 <= 1'b0;
      in_ready_p1  <= 1'b1;
      err_cnt_p1   <= '0;
    end else begin
      vld_p1       <= vld_nxt;
      skid_full_p1 <= skid_full_nxt;
      in_ready_p1  <= ~skid_full_nxt;
      if (load_from_skid) begin
        main_data_p1 <= skid_data_p1;
        main_err_p1  <= skid_err_p1;
      end else if (load_from_in) begin
        main_data_p1 <= sel_data_p0;
        main_err_p1  <= sel_err_p0;
      end
      if (bus.clr_err) begin
        err_cnt_p1 <= (accept && sel_err_p0) ? CNT_W'(1) : '0;
      end else if (accept && sel_err_p0) begin
        err_cnt_p1 <= sat_inc(err_cnt_p1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= sel_data_p0;
      skid_err_p1  <= sel_err_p0;
    end
  end

  assign bus.in_ready  = in_ready_p1;
  assign bus.out_data  = main_data_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_err   = main_err_p1;
  assign bus.err_cnt   = err_cnt_p1;

endmodule

// File: doc/mux_pipe_reg.md
Name: mux_pipe_reg

Overview:
- Parametrised, registered N:1 datapath multiplexer.
- Successor to the fixed-width, fixed-input combinational datapath muxes.
- Adds valid/ready flow control with a one-entry skid buffer, so a mux stage can sit on a pipeline boundary without a combinational ready path.
- Out-of-range select values return a defined default word, are flagged, and are counted; they never produce X.

Parameters:
- WIDTH, 32, data width of each input and of OUT.
- NUM_IN, 5, number of data inputs (2..16).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_IN.
- DEFAULT_VAL, 32'h0000_0000, value driven for an out-of-range select (WIDTH bits).
- CNT_W, 8, width of the error counter.

Ports:
- CLK  input  1  rising-edge clock.
- RESET_N  input  1  asynchronous, active-low reset.
- IN_BUS  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- SELECT  input  SEL_W  input index, sampled with IN_VALID.
- IN_VALID  input  1  upstream beat valid.
- IN_READY  output  1  stage can accept; registered.
- OUT  output  WIDTH  registered selected data.
- OUT_VALID  output  1  OUT holds a valid beat.
- OUT_READY  input  1  downstream accepts.
- OUT_ERR  output  1  current OUT beat came from an out-of-range select.
- ERR_CNT  output  CNT_W  saturating count of accepted out-of-range beats.
- CLR_ERR  input  1  synchronous clear of ERR_CNT.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - OUT=0, OUT_VALID=0, OUT_ERR=0, ERR_CNT=0.
  - Skid buffer empty; IN_READY=1.
  - Reset may assert at any time; any in-flight beat is discarded.
- Handshake events:
  - Accept = IN_VALID & IN_READY.
  - Transfer = OUT_VALID & OUT_READY.
- Select evaluation at accept:
  - SELECT < NUM_IN: data = IN_BUS slice at SELECT, err=0.
  - SELECT >= NUM_IN: data = DEFAULT_VAL, err=1.
- Storage: main register (OUT/OUT_VALID/OUT_ERR) plus one skid entry (data, err, full flag).
- Next-state rules, evaluated each rising edge:
  - Main empty or Transfer:
    - skid full: main <= skid, skid empties.
    - else if Accept: main <= input beat.
    - else: OUT_VALID <= 0.
  - Main full and no Transfer, with Accept: beat goes into skid; skid becomes full.
  - Skid full and no Transfer: everything holds; OUT and OUT_ERR stay stable while OUT_VALID=1 and OUT_READY=0.
  - IN_READY <= ~(next skid full). Accept cannot occur while skid is full.
- Latency and ordering:
  - Latency is 1 cycle from Accept to OUT_VALID when the stage is empty.
  - With OUT_READY=1 held, throughput is one beat per cycle.
  - Beat order is preserved; no beat is lost or duplicated.
- Error counter:
  - ERR_CNT increments on each Accept with err=1.
  - Saturates at 2**CNT_W-1; no wrap.
  - CLR_ERR alone: ERR_CNT <= 0.
  - CLR_ERR together with an erroneous Accept: ERR_CNT <= 1.
- Parameter legality: NUM_IN < 2 or 2**SEL_W < NUM_IN is a configuration error and must be caught at elaboration.

Test Plan:
- Reset then stream: NUM_IN=5, IN_BUS = {5,4,3,2,1}×0x11111111, SELECT=0..4 back to back, OUT_READY=1. Required: OUT = 0x11111111..0x55555555 in order, each one cycle after accept; OUT_ERR=0; IN_READY stays 1.
- Backpressure: OUT_READY=0, send beats A then B. Required:
  - OUT=A held, IN_READY=0 after B.
  - Beat C held off until OUT_READY=1.
  - Release gives A, B, C consecutively.
- Invalid select: SELECT=5, 6, 7. Required: OUT=DEFAULT_VAL with OUT_ERR=1 for each, ERR_CNT=3.
- Saturation/clear: CNT_W=2, six invalid beats. Required:
  - ERR_CNT=3 (no wrap).
  - CLR_ERR with an invalid accept gives ERR_CNT=1.
  - CLR_ERR alone gives 0.
- Reset mid-stream: skid full, OUT_VALID=1, assert RESET_N=0 between clock edges. Required: OUT_VALID=0, OUT=0, IN_READY=1 immediately; no stale beat after release.
- Parametric: WIDTH=8, NUM_IN=16, SEL_W=4, random valid/ready. Required: scoreboard matches IN_BUS[sel*8 +: 8] in order; OUT_ERR never set.
